delayed_and_filter: RTL
=======================

DELAYED_AND_FILTER -- requirements
Module: delayed_and_filter

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent AND channels, range 1..32.
REQ-002 Parameter ON_DELAY, default 3: consecutive cycles of (a&b)=1 required before s asserts, range 1..255.
REQ-003 Parameter OFF_DELAY, default 2: consecutive cycles of (a&b)=0 required before s deasserts, range 1..255.
REQ-004 Port clk input 1: single clock, all state on rising edge.
REQ-005 Port rst input 1: reset, synchronous and active-high.
REQ-006 Port en input 1: global enable; 0 forces all channels to IDLE.
REQ-007 Port a input CHANNELS: operand A per channel.
REQ-008 Port b input CHANNELS: operand B per channel.
REQ-009 Port s output CHANNELS: filtered, delayed AND result per channel, registered.

Function
REQ-010 Per channel, m[i]=a[i]&b[i] SHALL be sampled each rising clk edge; s[i] SHALL be driven only from a flop, never combinationally from a/b.
REQ-011 Each channel SHALL run a 4-state FSM: IDLE (s=0), RISE (s=0, counting), HIGH (s=1), FALL (s=1, counting).
REQ-012 IDLE: m=1 -> RISE with cnt=1, or directly HIGH if ON_DELAY=1; m=0 -> stay.
REQ-013 RISE: m=1 and cnt+1=ON_DELAY -> HIGH; m=1 otherwise -> cnt+1; m=0 -> IDLE, cnt=0.
REQ-014 HIGH: m=0 -> FALL with cnt=1, or directly IDLE if OFF_DELAY=1; m=1 -> stay.
REQ-015 FALL: m=0 and cnt+1=OFF_DELAY -> IDLE; m=0 otherwise -> cnt+1; m=1 -> HIGH, cnt=0.
REQ-016 Result: s rises after exactly ON_DELAY consecutive edges sampling m=1 and falls after exactly OFF_DELAY consecutive edges sampling m=0; pulses shorter than the delay SHALL produce no output change.
REQ-017 Counter width SHALL be clog2(max(ON_DELAY,OFF_DELAY)+1); the counter SHALL never wrap, since it is cleared on every state exit.
REQ-018 en=0 at an edge SHALL put every channel in IDLE with cnt=0 and s=0 after that edge, overriding m; counting restarts from zero when en returns to 1.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on any set of channels SHALL not interact.

Reset
REQ-020 rst=1 at an edge SHALL set every channel to IDLE, cnt=0, s=0 (and pulse outputs 0), with priority over en and m.
REQ-021 Reset asserted mid-RISE or mid-FALL SHALL discard the partial count; the first edge after rst deasserts is counted as cycle 1 if m=1.

Configuration
REQ-022 Macro DELAYED_AND_FILTER_PULSE_EN defined: adds outputs s_rise and s_fall (each CHANNELS wide), giving a one-cycle pulse in the cycle s[i] goes 0->1 or 1->0 respectively, including the 1->0 change forced by en=0.
REQ-023 Macro undefined: s_rise and s_fall, and their logic, SHALL not exist; all other behaviour is identical.

Structure
REQ-024 Package delayed_and_pkg SHALL hold the FSM state enum (IDLE, RISE, HIGH, FALL) and the parameter range-limit constants.
REQ-025 Per-channel logic SHALL be a sub-module delayed_and_chan (FSM + counter + s flop), instantiated CHANNELS times by generate; the top holds only the fan-out.

Verification
REQ-026 Stimulus: CHANNELS=4, ON=3, OFF=2; a=b=4'b0001 from edge 1 -> s[0]=1 after edge 3, s[3:1]=0 throughout.
REQ-027 Stimulus: m[1] high for 2 edges, low 1, high 3 -> s[1] stays 0 through the first pulse and rises after the 3rd edge of the second pulse.
REQ-028 Stimulus: s[2]=1, m[2] low for 1 edge then high -> s[2] stays 1 (FALL->HIGH); low for 2 edges -> s[2]=0 after edge 2.
REQ-029 Stimulus: rst pulsed for 1 cycle during RISE at cnt=2 -> s=0; with m held high, s rises 3 edges after rst deasserts.
REQ-030 Stimulus: all s=1, en=0 for 1 edge -> s=4'b0000 next cycle; with the pulse macro defined, s_fall=4'b1111 for exactly one cycle.
REQ-031 Stimulus: ON=1, OFF=1 -> s tracks m delayed by exactly one cycle on every channel.

Source files
------------

// File: rtl/delayed_and_pkg.sv
// Shared types and limits for the delayed AND filter: per-channel FSM state
// encoding and legal parameter ranges.
package delayed_and_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } chan_state_t;

  localparam int CHANNELS_MIN = 32'd1;
  localparam int CHANNELS_MAX = 32'd32;
  localparam int DELAY_MIN    = 32'd1;
  localparam int DELAY_MAX    = 32'd255;

  // Counter width large enough to hold the longer of the two delays.
  function automatic int cnt_width(input int on_delay, input int off_delay);
    int max_d;
    max_d = (on_delay > off_delay) ? on_delay : off_delay;
    return $clog2(max_d + 32'd1);
  endfunction

endpackage

// File: rtl/delayed_and_chan.sv
// One filtered AND channel: IDLE/RISE/HIGH/FALL debounce FSM with a shared
// delay counter. Optional edge pulses under DELAYED_AND_FILTER_PULSE_EN.
module delayed_and_chan
  import delayed_and_pkg::*;
#(
  parameter int ON_DELAY  = 3,
  parameter int OFF_DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s
`ifdef DELAYED_AND_FILTER_PULSE_EN
  ,
  output logic s_rise,
  output logic s_fall
`endif
);

  localparam int CW = cnt_width(ON_DELAY, OFF_DELAY);
  localparam logic [CW:0] ON_L  = (CW+1)'(ON_DELAY);
  localparam logic [CW:0] OFF_L = (CW+1)'(OFF_DELAY);

  chan_state_t   state_r, state_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic          s_r, s_next_s;
  logic          m_s;
  logic [CW:0]   cnt_inc_s;

  assign m_s       = a & b;
  assign cnt_inc_s = {1'b0, cnt_r} + (CW+1)'(1);

  // Next-state and counter update; en low overrides the sampled operand.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (!en) begin
      state_next_s = IDLE;
      cnt_next_s   = CW'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (m_s) begin
            if (ON_DELAY == 1) begin
              state_next_s = HIGH;
              cnt_next_s   = CW'(0);
            end else begin
              state_next_s = RISE;
              cnt_next_s   = CW'(1);
            end
          end else begin
            state_next_s = IDLE;
            cnt_next_s   = CW'(0);
          end
        end
        RISE: begin
          if (m_s) begin
            if (cnt_inc_s == ON_L) begin
              state_next_s = HIGH;
              cnt_next_s   = CW'(0);
            end else begin
              state_next_s = RISE;
              cnt_next_s   = cnt_inc_s[CW-1:0];
            end
          end else begin
            state_next_s = IDLE;
            cnt_next_s   = CW'(0);
          end
        end
        HIGH: begin
          if (!m_s) begin
            if (OFF_DELAY == 1) begin
              state_next_s = IDLE;
              cnt_next_s   = CW'(0);
            end else begin
              state_next_s = FALL;
              cnt_next_s   = CW'(1);
            end
          end else begin
            state_next_s = HIGH;
            cnt_next_s   = CW'(0);
          end
        end
        FALL: begin
          if (!m_s) begin
            if (cnt_inc_s == OFF_L) begin
              state_next_s = IDLE;
              cnt_next_s   = CW'(0);
            end else begin
              state_next_s = FALL;
              cnt_next_s   = cnt_inc_s[CW-1:0];
            end
          end else begin
            state_next_s = HIGH;
            cnt_next_s   = CW'(0);
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = CW'(0);
        end
      endcase
    end
  end

  assign s_next_s = (state_next_s == HIGH) || (state_next_s == FALL);

  // State, counter and output flops; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CW'(0);
      s_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      s_r     <= s_next_s;
    end
  end

  assign s = s_r;

`ifdef DELAYED_AND_FILTER_PULSE_EN
  logic s_rise_r, s_fall_r;

  // Edge pulses are registered alongside s so they coincide with its change.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rise_r <= 1'b0;
      s_fall_r <= 1'b0;
    end else begin
      s_rise_r <= s_next_s & ~s_r;
      s_fall_r <= ~s_next_s & s_r;
    end
  end

  assign s_rise = s_rise_r;
  assign s_fall = s_fall_r;
`endif

endmodule

// File: rtl/delayed_and_filter.sv
// Multi-channel delayed AND filter: fans out CHANNELS independent
// delayed_and_chan instances. Optional pulse outputs: DELAYED_AND_FILTER_PULSE_EN.
module delayed_and_filter
  import delayed_and_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int ON_DELAY  = 3,
  parameter int OFF_DELAY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] s
`ifdef DELAYED_AND_FILTER_PULSE_EN
  ,
  output logic [CHANNELS-1:0] s_rise,
  output logic [CHANNELS-1:0] s_fall
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    delayed_and_chan #(
      .ON_DELAY (ON_DELAY),
      .OFF_DELAY(OFF_DELAY)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .a     (a[i]),
      .b     (b[i]),
      .s     (s[i])
`ifdef DELAYED_AND_FILTER_PULSE_EN
      ,
      .s_rise(s_rise[i]),
      .s_fall(s_fall[i])
`endif
    );
  end

endmodule
